// File: rtl/rom_loader_pkg.sv
// Shared types and widths for the boot-time ROM loader.
// Optional checksum byte is enabled by defining ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;
   localparam int IDX_W       = 13;
   localparam int LEN_W       = 16;

   localparam logic [INST_ADDR_W-1:0] DEF_BASE_ADDR = 32'h0000_0000;
   localparam int                     DEF_MAX_WORDS = 4096;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // Byte address of word idx counted from base.
   function automatic logic [INST_ADDR_W-1:0] word_addr(
      input logic [INST_ADDR_W-1:0] base,
      input logic [IDX_W-1:0]       idx
   );
      return base + {{(INST_ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write-port output of the ROM loader.
interface rom_loader_if;

   // A byte moves on a rising edge where byte_valid_i and byte_ready_o are
   // both high; byte_ready_o is registered and the source may drop
   // byte_valid_i at any time without consequence.
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_i;
   logic        byte_ready_o;
   logic [31:0] w_addr_o;
   logic        w_en_o;
   logic [31:0] w_data_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        cpu_hold_o;

   modport master (
      output start_i, byte_valid_i, byte_i,
      input  byte_ready_o, w_addr_o, w_en_o, w_data_o,
      input  busy_o, done_o, err_o, cpu_hold_o
   );

   modport slave (
      input  start_i, byte_valid_i, byte_i,
      output byte_ready_o, w_addr_o, w_en_o, w_data_o,
      output busy_o, done_o, err_o, cpu_hold_o
   );

endinterface

// File: rtl/rom_loader_packer.sv
// Little-endian shift-in packer: four accepted bytes form one 32-bit word,
// first byte ending up in bits [7:0].
module rom_loader_packer
   import rom_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_in,
   output logic [INST_W-1:0] packed_word,
   output logic              word_ready
);

   logic [INST_W-1:0] word;
   logic [1:0]        count;

   // Word as it stands once the current byte is shifted in, so the caller can
   // register a complete word on the same edge that takes the 4th byte.
   assign packed_word = {byte_in, word[INST_W-1:8]};
   assign word_ready  = byte_en && (count == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word  <= '0;
         count <= 2'd0;
      end else if (clear) begin
         word  <= '0;
         count <= 2'd0;
      end else if (byte_en) begin
         word  <= packed_word;
         count <= count + 2'd1;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Length-prefixed byte stream to 32-bit instruction ROM writer; holds the core
// while loading. Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int                     MAX_WORDS = DEF_MAX_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   rom_loader_if.slave bus,
   output state_t      dbg_state
);

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

   state_t                 state;
   logic [7:0]             len_lo;
   logic [LEN_W-1:0]       len;
   logic [IDX_W-1:0]       idx;
   logic                   byte_ready;
   logic [INST_ADDR_W-1:0] w_addr;
   logic                   w_en;
   logic [INST_W-1:0]      w_data;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   cpu_hold;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]             csum;
`endif

   logic                   accept;
   logic                   restart;
   logic                   data_en;
   logic [LEN_W-1:0]       len_n;
   logic                   len_bad;
   logic [IDX_W-1:0]       idx_inc;
   logic                   last_word;
   logic [INST_W-1:0]      pk_word;
   logic                   pk_last;

   assign accept    = bus.byte_valid_i && byte_ready;
   assign restart   = bus.start_i &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign data_en   = accept && (state == S_DATA);
   assign len_n     = {bus.byte_i, len_lo};
   assign len_bad   = (len_n == '0) || ({1'b0, len_n} > MAX_LEN);
   assign idx_inc   = idx + 1'b1;
   assign last_word = ({{(LEN_W-IDX_W){1'b0}}, idx_inc} == len);

   rom_loader_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clear       (restart),
      .byte_en     (data_en),
      .byte_in     (bus.byte_i),
      .packed_word (pk_word),
      .word_ready  (pk_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         len_lo     <= '0;
         len        <= '0;
         idx        <= '0;
         byte_ready <= 1'b0;
         w_addr     <= '0;
         w_en       <= 1'b0;
         w_data     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_hold   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else if (restart) begin
         // Same entry path from IDLE, DONE (reload) and ERR (retry).
         state      <= S_LEN_LO;
         idx        <= '0;
         byte_ready <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_hold   <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         case (state)
            S_LEN_LO: begin
               if (accept) begin
                  len_lo <= bus.byte_i;
                  state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len <= len_n;
                  if (len_bad) begin
                     state      <= S_ERR;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     err        <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                  csum <= csum ^ bus.byte_i;
`endif
                  if (pk_last) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     w_en       <= 1'b1;
                     w_addr     <= word_addr(BASE_ADDR, idx);
                     w_data     <= pk_word;
                  end
               end
            end
            S_WRITE: begin
               w_en <= 1'b0;
               idx  <= idx_inc;
               if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                  state      <= S_CHECK;
                  byte_ready <= 1'b1;
`else
                  state    <= S_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  state      <= S_DATA;
                  byte_ready <= 1'b1;
               end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (accept) begin
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                  if (bus.byte_i == csum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     // Words already written stay; the core remains held.
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.byte_ready_o = byte_ready;
   assign bus.w_addr_o     = w_addr;
   assign bus.w_en_o       = w_en;
   assign bus.w_data_o     = w_data;
   assign bus.busy_o       = busy;
   assign bus.done_o       = done;
   assign bus.err_o        = err;
   assign bus.cpu_hold_o   = cpu_hold;
   assign dbg_state        = state;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of load vectors plus reset, checksum
// and full-depth sequences on a second instance with BASE_ADDR 0x100.
module tb_rom_loader;
   import rom_loader_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rom_loader_if bus0();
   rom_loader_if bus1();
   state_t st0;
   state_t st1;

   rom_loader dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .dbg_state (st0)
   );

   rom_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4096)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1),
      .dbg_state (st1)
   );

   assign bus1.start_i      = bus0.start_i;
   assign bus1.byte_valid_i = bus0.byte_valid_i;
   assign bus1.byte_i       = bus0.byte_i;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   int          rd = 0;
   int          dbl_en = 0;
   logic        prev_en0 = 1'b0;
   int          d1_cnt = 0;
   logic [31:0] d1_last_addr = '0;
   logic [31:0] d1_last_data = '0;

   always @(negedge clk) begin
      if (bus0.w_en_o) got_q.push_back({bus0.w_addr_o, bus0.w_data_o});
      if (bus0.w_en_o && prev_en0) dbl_en++;
      prev_en0 = bus0.w_en_o;
      if (bus1.w_en_o) begin
         d1_cnt++;
         d1_last_addr = bus1.w_addr_o;
         d1_last_data = bus1.w_data_o;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_writes(input string name);
      logic [63:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd < got_q.size()) begin
            chk(name, got_q[rd], e);
            rd++;
         end else begin
            checks++;
            errors++;
            $display("FAIL %s_missing actual=none expected=%h", name, e);
         end
      end
      chk({name, "_extra"}, 64'(got_q.size() - rd), 64'd0);
      rd = got_q.size();
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start;
      @(posedge clk); #1 bus0.start_i = 1'b1;
      @(posedge clk); #1 bus0.start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok = 1'b0;
      if (gaps) begin
         bus0.byte_valid_i = 1'b0;
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      bus0.byte_i       = b;
      bus0.byte_valid_i = 1'b1;
      for (int t = 0; t < 32; t++) begin
         @(negedge clk);
         ok = bus0.byte_ready_o;
         @(posedge clk); #1;
         if (ok) break;
      end
      bus0.byte_valid_i = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout actual=not_ready expected=ready");
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gaps);
   endtask

   function automatic logic [7:0] xor_word(input logic [31:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

   task automatic wait_end(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (bus0.done_o || bus0.err_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_end expected=done_or_err", name);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct packed {
      logic [15:0]      len;
      logic [1:0]       nw;
      logic [2:0][31:0] w;
      logic             gaps;
      logic             exp_done;
      logic             exp_err;
      logic             exp_hold;
      logic [1:0]       exp_writes;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input int i, input vec_t v);
      string nm;
      logic [7:0] cs = 8'h00;
      nm = $sformatf("v%0d", i);
      for (int k = 0; k < int'(v.exp_writes); k++)
         exp_q.push_back({32'(4 * k), v.w[k]});
      pulse_start;
      chk({nm, "_start_flags"},
          {60'd0, bus0.busy_o, bus0.cpu_hold_o, bus0.done_o, bus0.err_o}, 64'b1100);
      send_byte(v.len[7:0], v.gaps);
      send_byte(v.len[15:8], v.gaps);
      for (int k = 0; k < int'(v.nw); k++) begin
         send_word(v.w[k], v.gaps);
         cs = cs ^ xor_word(v.w[k]);
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      if (v.nw != 2'd0) send_byte(cs, v.gaps);
`endif
      wait_end(nm);
      chk({nm, "_end_flags"},
          {60'd0, bus0.done_o, bus0.err_o, bus0.cpu_hold_o, bus0.busy_o},
          {60'd0, v.exp_done, v.exp_err, v.exp_hold, 1'b0});
      if (v.exp_writes != 2'd0)
         chk({nm, "_held_addr"}, 64'(bus0.w_addr_o), 64'(4 * (int'(v.exp_writes) - 1)));
      check_writes({nm, "_writes"});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d1_base;
      logic [7:0] cs;

      vecs[0] = '{16'h0002, 2'd2, {32'h0, 32'hDEADBEEF, 32'h12345678},
                  1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
      vecs[1] = '{16'h0000, 2'd0, {32'h0, 32'h0, 32'h0},
                  1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[2] = '{16'h1001, 2'd0, {32'h0, 32'h0, 32'h0},
                  1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[3] = '{16'h0003, 2'd3, {32'h55AA33CC, 32'h0BADC0DE, 32'hCAFEF00D},
                  1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
      vecs[4] = '{16'h0003, 2'd3, {32'h55AA33CC, 32'h0BADC0DE, 32'hCAFEF00D},
                  1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
      vecs[5] = '{16'h0001, 2'd1, {32'h0, 32'h0, 32'h08040201},
                  1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
      vecs[6] = '{16'hFFFF, 2'd0, {32'h0, 32'h0, 32'h0},
                  1'b0, 1'b0, 1'b1, 1'b1, 2'd0};

      bus0.start_i      = 1'b0;
      bus0.byte_valid_i = 1'b0;
      bus0.byte_i       = 8'h00;

      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {bus0.w_addr_o, bus0.w_data_o} |
          {56'd0, bus0.w_en_o, bus0.byte_ready_o, bus0.busy_o, bus0.done_o,
           bus0.err_o, bus0.cpu_hold_o, 2'b00}, 64'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Bytes offered while idle must not be taken.
      bus0.byte_i = 8'hA5;
      bus0.byte_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready", {63'd0, bus0.byte_ready_o}, 64'd0);
      chk("idle_state", 64'(st0), 64'(S_IDLE));
      @(posedge clk); #1 bus0.byte_valid_i = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Reset after 6 data bytes of an N=2 load.
      exp_q.push_back({32'h0, 32'h12345678});
      pulse_start;
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'h12345678, 1'b0);
      send_byte(8'hEF, 1'b0);
      send_byte(8'hBE, 1'b0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_outputs",
          {bus0.w_addr_o, bus0.w_data_o} |
          {56'd0, bus0.w_en_o, bus0.byte_ready_o, bus0.busy_o, bus0.done_o,
           bus0.err_o, bus0.cpu_hold_o, 2'b00}, 64'd0);
      chk("midreset_state", 64'(st0), 64'(S_IDLE));
      check_writes("midreset_writes");
      @(posedge clk); #1 rst = 1'b1;
      run_vec(7, vecs[0]);

`ifdef ROM_LOADER_CHECKSUM_EN
      // Bad checksum: word still lands, load ends in ERR with core held.
      exp_q.push_back({32'h0, 32'h08040201});
      pulse_start;
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'h08040201, 1'b0);
      send_byte(8'h0E, 1'b0);
      wait_end("csum_bad");
      chk("csum_bad_flags",
          {61'd0, bus0.done_o, bus0.err_o, bus0.cpu_hold_o}, 64'b011);
      check_writes("csum_bad_writes");
`endif

      // Full-depth load; start pulse mid-load must be ignored.
      d1_base = d1_cnt;
      cs = 8'h00;
      for (int k = 0; k < 4096; k++)
         exp_q.push_back({32'(4 * k), 32'h1000_0000 + 32'(k)});
      pulse_start;
      send_byte(8'h00, 1'b0);
      send_byte(8'h10, 1'b0);
      for (int k = 0; k < 4096; k++) begin
         if (k == 100) pulse_start;
         send_word(32'h1000_0000 + 32'(k), 1'b0);
         cs = cs ^ xor_word(32'h1000_0000 + 32'(k));
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      send_byte(cs, 1'b0);
`endif
      wait_end("full");
      chk("full_d1_count", 64'(d1_cnt - d1_base), 64'd4096);
      chk("full_d1_last", {d1_last_addr, d1_last_data}, {32'h0000_40FC, 32'h1000_0FFF});
      chk("full_d1_flags",
          {61'd0, bus1.done_o, bus1.cpu_hold_o, bus1.busy_o}, 64'b100);
      chk("full_d1_state", 64'(st1), 64'(S_DONE));
      chk("full_d0_done", {63'd0, bus0.done_o}, 64'd1);
      check_writes("full_d0_writes");

      chk("single_cycle_wen", 64'(dbl_en), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
